// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU writeback (A) and load return (B).
// Clears every register after reset; define ZERO_REG_PROTECT_EN to make register 0 read-only in RUN.
module regfile_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              init_done
);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic              rr_last;     // 1 = port B was granted last
    logic              xfer;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_cnt == LAST_IDX) begin
            state_next = RUN;
        end
    end

    // Grant goes to the port that did not win last time when both request.
    always_comb begin
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        init_done = (state == RUN);
        if (state == RUN) begin
            if (a_valid && (!b_valid || rr_last)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    always_comb begin
        xfer    = a_ready || b_ready;
        wr_addr = a_ready ? a_addr : b_addr;
        wr_data = a_ready ? a_data : b_data;
`ifdef ZERO_REG_PROTECT_EN
        wr_en   = xfer && (wr_addr != '0);
`else
        wr_en   = xfer;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clr_cnt <= '0;
            rr_last <= 1'b1;
            we3     <= 1'b0;
            wa3     <= '0;
            wd3     <= '0;
        end else if (state == CLEAR) begin
            we3     <= 1'b1;
            wa3     <= clr_cnt;
            wd3     <= '0;
            clr_cnt <= clr_cnt + 1'b1;
        end else begin
            we3 <= wr_en;
            if (wr_en) begin
                wa3 <= wr_addr;
                wd3 <= wr_data;
            end
            if (xfer) begin
                rr_last <= b_ready;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: post-reset clear, single writes, contention, resets.
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        reset_n;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        init_done;

    int checks = 0;
    int failures = 0;

    regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .we3(we3), .wa3(wa3), .wd3(wd3), .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive requests, check readies, pass one edge, check write port.
    task automatic cyc(input string tag,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic exp_ar, input logic exp_br,
                       input logic exp_we, input logic [4:0] exp_wa, input logic [31:0] exp_wd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        check_eq({tag, "_a_ready"}, a_ready, exp_ar);
        check_eq({tag, "_b_ready"}, b_ready, exp_br);
        @(negedge clk);
        check_eq({tag, "_we3"}, we3, exp_we);
        check_eq({tag, "_wa3"}, wa3, exp_wa);
        check_eq({tag, "_wd3"}, wd3, exp_wd);
    endtask

    // Checks n clear cycles starting at register 0, with both ports requesting meanwhile.
    task automatic clear_seq(input int n);
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
        b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h88;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("clr_we3", we3, 1'b1);
            check_eq("clr_wa3", wa3, i);
            check_eq("clr_wd3", wd3, 0);
            check_eq("clr_init_done", init_done, (i == 31));
            if (i < 31) begin
                check_eq("clr_a_ready", a_ready, 1'b0);
                check_eq("clr_b_ready", b_ready, 1'b0);
            end
            if (i >= 30) begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h0;
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_we3", we3, 1'b0);
        check_eq("rst_wa3", wa3, 0);
        check_eq("rst_wd3", wd3, 0);
        check_eq("rst_init_done", init_done, 1'b0);
        check_eq("rst_a_ready", a_ready, 1'b0);
        check_eq("rst_b_ready", b_ready, 1'b0);

        reset_n = 1'b1;
        clear_seq(32);
        cyc("idle0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd31, 32'h0);
        check_eq("run_init_done", init_done, 1'b1);

        // single A write, then nothing pending
        cyc("a1", 1, 5'd1, 32'hA5A5A5A5, 0, 0, 0, 1, 0, 1, 5'd1, 32'hA5A5A5A5);
        cyc("a1_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 32'hA5A5A5A5);

        // only B requesting: granted back to back even after winning
        cyc("b4", 0, 0, 0, 1, 5'd4, 32'h44, 0, 1, 1, 5'd4, 32'h44);
        cyc("b5", 0, 0, 0, 1, 5'd5, 32'h55, 0, 1, 1, 5'd5, 32'h55);
        cyc("b6", 0, 0, 0, 1, 5'd6, 32'h66, 0, 1, 1, 5'd6, 32'h66);

        // continuous contention alternates starting with A
        cyc("ab0", 1, 5'd2, 32'h11, 1, 5'd3, 32'h22, 1, 0, 1, 5'd2, 32'h11);
        cyc("ab1", 1, 5'd2, 32'h11, 1, 5'd3, 32'h22, 0, 1, 1, 5'd3, 32'h22);
        cyc("ab2", 1, 5'd2, 32'h11, 1, 5'd3, 32'h22, 1, 0, 1, 5'd2, 32'h11);
        cyc("ab3", 1, 5'd2, 32'h11, 1, 5'd3, 32'h22, 0, 1, 1, 5'd3, 32'h22);

        // same destination: A then B, B's data remains
        cyc("same0", 1, 5'd7, 32'h77, 1, 5'd7, 32'h88, 1, 0, 1, 5'd7, 32'h77);
        cyc("same1", 0, 0, 0, 1, 5'd7, 32'h88, 0, 1, 1, 5'd7, 32'h88);
        cyc("same_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 32'h88);

`ifdef ZERO_REG_PROTECT_EN
        cyc("zero", 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 5'd7, 32'h88);
`else
        cyc("zero", 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 5'd0, 32'hFFFFFFFF);
`endif

        // reset during RUN traffic drops the request
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
        b_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("rrun_we3", we3, 1'b0);
        check_eq("rrun_wa3", wa3, 0);
        check_eq("rrun_wd3", wd3, 0);
        check_eq("rrun_init_done", init_done, 1'b0);
        check_eq("rrun_a_ready", a_ready, 1'b0);

        // reset mid-clear at clr_cnt=10 restarts from register 0
        reset_n = 1'b1;
        clear_seq(10);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("rclr_we3", we3, 1'b0);
        check_eq("rclr_wa3", wa3, 0);
        check_eq("rclr_init_done", init_done, 1'b0);
        reset_n = 1'b1;
        clear_seq(32);
        cyc("idle_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd31, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
